zpu_io_uart: RTL and testbench

Memory-mapped I/O slave that sits directly on the ZPU small core's memory port: it consumes the core's address/write/enable/mask strobes and returns read data plus the busy handshake. It provides three things:
- a buffered 8N1 UART transmitter whose status word puts "not tx_full" on bit 8, the bit the firmware polls before every `putchar`;
- a sticky overflow flag;
- a 32-bit free-running cycle counter used for benchmark timing.

Address decode of the I/O region is external; this block sees only accesses that are already selected.

---
 rtl/zpu_io_uart.sv | 167 ++++++++++++++++
 tb/tb_zpu_io_uart.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zpu_io_uart.sv
// rtl/zpu_io_uart.sv - ZPU memory-port I/O slave: buffered 8N1 UART TX, sticky overflow, cycle counter
// Word 0 = UART data/status, 1 = counter, 2 = counter clear, 3 = reserved.
module zpu_io_uart #(
  parameter int DIVISOR = 434,
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [27:0] mem_addr,
  input  logic [31:0] mem_write,
  input  logic        mem_writeEnable,
  input  logic        mem_readEnable,
  input  logic [3:0]  mem_writeMask,
  output logic [31:0] mem_read,
  output logic        mem_busy,
  output logic        txd
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [15:0] BAUD_RELOAD = 16'(DIVISOR - 1);
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  tx_state_t          state;
  logic [15:0]        baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               overflow;
  logic [31:0]        counter;
  logic               rd_pending;
  logic [31:0]        rd_hold;
  logic [31:0]        read_mux;
  logic [31:0]        status;
  logic [1:0]         word;
  logic               accept, do_write, do_read;
  logic               full, empty, tx_idle;
  logic               push_req, push, pop, clear;
  logic               unused_bits;

  assign unused_bits = ^{mem_addr[27:4], mem_addr[1:0], mem_write[31:8], mem_writeMask[3:1]};

  // A busy cycle swallows any strobe; a combined read+write acts as a write only.
  assign word     = mem_addr[3:2];
  assign accept   = (mem_writeEnable | mem_readEnable) & ~mem_busy;
  assign do_write = accept & mem_writeEnable;
  assign do_read  = accept & mem_readEnable & ~mem_writeEnable;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign tx_idle  = empty && (state == IDLE);
  assign push_req = do_write && (word == 2'd0) && mem_writeMask[0];
  assign push     = push_req && !full;
  assign pop      = (state == IDLE) && !empty;
  assign clear    = do_write && (word == 2'd2) && mem_write[0];
  assign status   = {21'b0, tx_idle, overflow, ~full, 8'b0};

  always_comb begin
    read_mux = '0;
    case (word)
      2'd0:    read_mux = status;
      2'd1:    read_mux = counter;
      default: read_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_write[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full)
        overflow <= 1'b1;
      else if (do_read && (word == 2'd0))
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) counter <= '0;
    else                counter <= counter + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_busy   <= 1'b0;
      mem_read   <= '0;
      rd_pending <= 1'b0;
      rd_hold    <= '0;
    end else begin
      mem_busy   <= accept;
      rd_pending <= do_read;
      if (do_read)    rd_hold  <= read_mux;
      if (rd_pending) mem_read <= rd_hold;
    end
  end

  // The shift register is consumed LSB first as data bits go out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (!empty) begin
            shift    <= fifo_mem[rd_ptr];
            state    <= START;
            txd      <= 1'b0;
            baud_cnt <= BAUD_RELOAD;
          end
        end
        START: begin
          if (baud_cnt == '0) begin
            state    <= DATA;
            txd      <= shift[0];
            shift    <= {1'b0, shift[7:1]};
            bit_idx  <= '0;
            baud_cnt <= BAUD_RELOAD;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shift[0];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          txd <= 1'b1;
          if (baud_cnt == '0) state <= IDLE;
          else                baud_cnt <= baud_cnt - 16'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_zpu_io_uart.sv
// tb/tb_zpu_io_uart.sv - scoreboard bench for zpu_io_uart with a transaction-level FIFO/UART/counter model
module tb_zpu_io_uart;
  localparam int D = 4;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [27:0] mem_addr = '0;
  logic [31:0] mem_write = '0;
  logic        mem_writeEnable = 1'b0;
  logic        mem_readEnable = 1'b0;
  logic [3:0]  mem_writeMask = '0;
  logic [31:0] mem_read;
  logic        mem_busy;
  logic        txd;

  zpu_io_uart #(.DIVISOR(D), .FIFO_AW(AW)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_writeEnable(mem_writeEnable), .mem_readEnable(mem_readEnable),
    .mem_writeMask(mem_writeMask), .mem_read(mem_read), .mem_busy(mem_busy), .txd(txd)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Model: push cycles of queued bytes, first cycle the shifter may pop, counter zero point.
  int          mq_t[$];
  int          next_pop = 0;
  int          zero_cyc = 0;
  logic        ovf_m = 1'b0;
  logic [31:0] last_rd = '0;
  logic [7:0]  exp_tx[$];
  logic [31:0] rd_q[$];
  int          starts[$];
  int          last_start = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // A byte leaves the FIFO one cycle after it lands, or when the previous frame
  // (10*D cycles) plus one idle cycle is over, whichever is later.
  function automatic void model_advance(input int n);
    int pc;
    while (mq_t.size() > 0) begin
      pc = (mq_t[0] + 1 > next_pop) ? mq_t[0] + 1 : next_pop;
      if (pc >= n) break;
      void'(mq_t.pop_front());
      next_pop = pc + 10 * D + 1;
    end
  endfunction

  task automatic access(input bit we, input bit re, input logic [1:0] word,
                        input logic [31:0] data, input logic [3:0] mask, output int n);
    int guard;
    logic [31:0] r;
    guard = 0;
    r = $urandom;
    @(negedge clk);
    while (mem_busy && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    n = cyc;
    mem_addr = {r[23:0], word, r[25:24]};
    mem_write = data;
    mem_writeMask = mask;
    mem_writeEnable = we;
    mem_readEnable = re;
    model_advance(n);
    if (we) begin
      if (word == 2'd0 && mask[0]) begin
        if (mq_t.size() == DEPTH) ovf_m = 1'b1;
        else begin
          mq_t.push_back(n);
          exp_tx.push_back(data[7:0]);
        end
      end else if (word == 2'd2 && data[0]) begin
        zero_cyc = n + 1;
      end
    end else begin
      case (word)
        2'd0: begin
          last_rd = {21'b0, (mq_t.size() == 0 && n >= next_pop), ovf_m, (mq_t.size() != DEPTH), 8'b0};
          ovf_m = 1'b0;
        end
        2'd1: last_rd = 32'(n - zero_cyc);
        default: last_rd = '0;
      endcase
    end
    rd_q.push_back(last_rd);
    @(negedge clk);
    mem_writeEnable = 1'b0;
    mem_readEnable = 1'b0;
    @(negedge clk);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    reset = 1'b1;
    mq_t.delete();
    exp_tx.delete();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    next_pop = cyc;
    zero_cyc = cyc;
    ovf_m = 1'b0;
    last_rd = '0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_tx.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    check("tx_drain_left", exp_tx.size(), 0);
  endtask

  // Read/busy monitor: every accepted strobe yields one busy cycle, then mem_read is compared.
  initial begin : rd_mon
    int bcnt;
    logic [31:0] e;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (reset) bcnt = 0;
      else if (mem_busy) bcnt++;
      else if (bcnt != 0) begin
        check("busy_len", bcnt, 1);
        if (rd_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL mem_read: unexpected completion, got 0x%08h", mem_read);
        end else begin
          e = rd_q.pop_front();
          check("mem_read", mem_read, e);
        end
        bcnt = 0;
      end
    end
  end

  // Frame monitor: samples every cycle of a frame; any mid-bit change counts as a glitch.
  initial begin : tx_mon
    logic [9:0] obs;
    logic [7:0] e;
    bit glitch, aborted;
    forever begin
      @(negedge clk);
      if (!reset && txd === 1'b0) begin
        obs = '0;
        glitch = 0;
        aborted = 0;
        starts.push_back(cyc);
        last_start = cyc;
        for (int i = 0; i < 10 * D; i++) begin
          if (i > 0) @(negedge clk);
          if (reset) begin
            aborted = 1;
            break;
          end
          if (i % D == 0) obs[i / D] = txd;
          else if (txd !== obs[i / D]) glitch = 1;
        end
        if (!aborted) begin
          if (exp_tx.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL tx_frame: unexpected frame bits 0x%03h", obs);
          end else begin
            e = exp_tx.pop_front();
            check("tx_frame", {21'b0, glitch, obs}, {21'b0, 1'b0, 1'b1, e, 1'b0});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, n0, sb, g, kind, gap;
    bit hi;
    logic [31:0] rdat;
    logic [1:0] w;

    assert_reset();
    repeat (2) @(negedge clk);
    release_reset();
    check("rst_mem_read", mem_read, 32'h0);
    check("rst_mem_busy", {31'b0, mem_busy}, 32'h0);
    check("rst_txd", {31'b0, txd}, 32'h1);

    access(0, 1, 2'd0, 32'h0, 4'h0, n);
    check("status_after_reset", mem_read, 32'h500);

    access(1, 0, 2'd0, 32'h55, 4'hF, n);
    @(negedge clk);
    check("start_cycle", last_start, n + 2);
    wait_drain();
    access(0, 1, 2'd0, 32'h0, 4'h0, n);
    check("status_after_55", mem_read, 32'h500);

    sb = starts.size();
    for (int i = 0; i < 6; i++) begin
      rdat = $urandom;
      access(1, 0, 2'd0, rdat, 4'hF, n);
      @(negedge clk);
    end
    access(0, 1, 2'd0, 32'h0, 4'h0, n);
    check("burst_status_full_ovf", {30'b0, mem_read[9:8]}, 32'h2);
    access(0, 1, 2'd0, 32'h0, 4'h0, n);
    check("burst_ovf_cleared", {31'b0, mem_read[9]}, 32'h0);
    wait_drain();
    check("burst_frames", starts.size() - sb, 5);
    if (starts.size() >= sb + 2) check("b2b_gap", starts[sb + 1] - starts[sb], 10 * D + 1);

    access(1, 0, 2'd0, 32'hA3, 4'hE, n);
    hi = 1;
    repeat (12) begin
      @(negedge clk);
      hi &= txd;
    end
    check("mask_no_tx", {31'b0, hi}, 32'h1);
    access(0, 1, 2'd0, 32'h0, 4'h0, n);
    check("mask_status", mem_read, 32'h500);

    access(1, 0, 2'd2, 32'h1, 4'hF, n0);
    while (cyc < n0 + 9) @(negedge clk);
    access(0, 1, 2'd1, 32'h0, 4'h0, n);
    check("counter_after_clear", mem_read, 32'd9);

    @(negedge clk);
    force dut.counter = 32'hFFFF_FFFE;
    #1 release dut.counter;
    zero_cyc = cyc + 2;
    @(negedge clk);
    access(0, 1, 2'd1, 32'h0, 4'h0, n);
    check("counter_wrap", mem_read, 32'h0);

    for (int i = 0; i < 80; i++) begin
      w = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      rdat = $urandom;
      if (kind < 5) access(1, 0, w, rdat, 4'($urandom_range(0, 15)), n);
      else if (kind < 9) access(0, 1, w, rdat, 4'h0, n);
      else access(1, 1, w, rdat, 4'($urandom_range(0, 15)), n);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end
    wait_drain();

    access(1, 0, 2'd0, 32'h3C, 4'hF, n0);
    access(1, 0, 2'd0, 32'hC3, 4'hF, n);
    access(1, 0, 2'd0, 32'h5A, 4'hF, n);
    while (cyc < n0 + 16) @(negedge clk);
    assert_reset();
    @(negedge clk);
    check("reset_txd_next", {31'b0, txd}, 32'h1);
    release_reset();
    hi = 1;
    repeat (60) begin
      @(negedge clk);
      hi &= txd;
    end
    check("reset_no_resume", {31'b0, hi}, 32'h1);
    access(0, 1, 2'd0, 32'h0, 4'h0, n);
    check("status_after_midframe_reset", mem_read, 32'h500);

    g = 0;
    while (rd_q.size() != 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("rd_q_left", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
